// File: rtl/mod_operand_stage.sv
// Operand guard stage for a MOD unit: a 2-entry skid buffer that flags and replaces zero divisors.
// Optional build macro MOD_OPERAND_STAGE_DZCNT_EN adds an 8-bit saturating zero-divisor counter output.
module mod_operand_stage #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_a,
    input  logic [DATAWIDTH-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_a,
    output logic [DATAWIDTH-1:0] out_b,
    output logic                 out_dz
`ifdef MOD_OPERAND_STAGE_DZCNT_EN
    ,
    output logic [7:0]           dz_count
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t                 state_q, state_d;
    logic                   in_ready_q, out_valid_q;
    logic [DATAWIDTH-1:0]   main_a_q, main_b_q, skid_a_q, skid_b_q;
    logic                   main_dz_q, skid_dz_q;
    logic                   accept, drain;
    logic                   load_main, load_skid, move_skid;
    logic                   cap_dz;
    logic [DATAWIDTH-1:0]   cap_b;

    // A zero divisor becomes 1 so the downstream remainder is a defined 0.
    function automatic logic [DATAWIDTH-1:0] guard_b(input logic [DATAWIDTH-1:0] b);
        return (b == '0) ? DATAWIDTH'(1) : b;
    endfunction

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;
    assign cap_dz = (in_b == '0);
    assign cap_b  = guard_b(in_b);

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                case ({accept, drain})
                    2'b10: begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: load_main = 1'b1;
                    default: state_d = ONE;
                endcase
            end
            TWO: begin
                if (drain) begin
                    state_d   = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs are registered from the next state so they never glitch.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_a_q    <= '0;
            main_b_q    <= '0;
            main_dz_q   <= 1'b0;
            skid_a_q    <= '0;
            skid_b_q    <= '0;
            skid_dz_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
            if (load_main) begin
                main_a_q  <= in_a;
                main_b_q  <= cap_b;
                main_dz_q <= cap_dz;
            end else if (move_skid) begin
                main_a_q  <= skid_a_q;
                main_b_q  <= skid_b_q;
                main_dz_q <= skid_dz_q;
            end
            if (load_skid) begin
                skid_a_q  <= in_a;
                skid_b_q  <= cap_b;
                skid_dz_q <= cap_dz;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_a     = main_a_q;
    assign out_b     = main_b_q;
    assign out_dz    = main_dz_q;

`ifdef MOD_OPERAND_STAGE_DZCNT_EN
    logic [7:0] dz_cnt_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            dz_cnt_q <= 8'd0;
        end else if (accept && cap_dz && (dz_cnt_q != 8'hFF)) begin
            dz_cnt_q <= dz_cnt_q + 8'd1;
        end
    end

    assign dz_count = dz_cnt_q;
`endif

endmodule

// File: doc/mod_operand_stage.md
MOD_OPERAND_STAGE -- requirements
Module: mod_operand_stage

Interface
REQ-001 Parameter DATAWIDTH, default 8, SHALL set the operand width in bits; legal values are 2, 8, 16, 32 and 64.
REQ-002 Clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL indicate that the producer presents an operand pair.
REQ-005 in_ready  output  1  SHALL indicate that the stage can accept a pair; it SHALL be a registered output.
REQ-006 in_a, in_b  input  DATAWIDTH each  SHALL carry the dividend and the divisor.
REQ-007 out_valid  output  1  SHALL indicate that a pair is presented to the downstream MOD unit.
REQ-008 out_ready  input  1  SHALL indicate that the consumer accepts the pair.
REQ-009 out_a, out_b  output  DATAWIDTH each  SHALL carry the guarded dividend and divisor.
REQ-010 out_dz  output  1  SHALL flag that the original divisor was zero.

Function
REQ-011 The stage SHALL transfer a pair on the input side when in_valid && in_ready is high at a Clk edge, and on the output side when out_valid && out_ready is high at a Clk edge.
REQ-012 The stage SHALL be a 2-entry skid buffer with a main register and a skid register, controlled by states EMPTY, ONE and TWO.
REQ-013 State transitions SHALL be:
- EMPTY, accept -> ONE.
- ONE, accept without drain -> TWO.
- ONE, drain without accept -> EMPTY.
- ONE, accept and drain -> ONE, with the main register reloaded.
- TWO, drain -> ONE, with the skid register moved into the main register.
REQ-014 In TWO, in_ready SHALL be 0; in EMPTY and ONE, in_ready SHALL be 1.
REQ-015 out_valid SHALL be 1 exactly in ONE and TWO.
REQ-016 out_a, out_b and out_dz SHALL always reflect the main register, which holds the oldest pair.
REQ-017 Latency SHALL be one cycle: a pair accepted at edge N appears at the outputs after edge N when the stage was EMPTY.
REQ-018 Throughput SHALL be one pair per cycle when out_ready is held high.
REQ-019 On capture, the stage SHALL compute dz = (in_b == 0).
REQ-020 When dz is 1, the stage SHALL store out_b = 1 with out_a unchanged, so the downstream remainder is 0 and never undefined.
REQ-021 When dz is 0, the stage SHALL store in_b unmodified.
REQ-022 Pairs SHALL leave in acceptance order; no pair SHALL be dropped or duplicated.
REQ-023 While out_valid is 1 and out_ready is 0, out_a, out_b and out_dz SHALL remain stable.
REQ-024 When in_valid is high while in_ready is 0, the stage SHALL ignore the inputs.
REQ-025 In ONE with simultaneous accept and drain, occupancy SHALL stay one and the new pair SHALL appear the next cycle.

Reset
REQ-026 Assertion of Rst SHALL immediately force EMPTY, in_ready=1, out_valid=0, out_a=0, out_b=0 and out_dz=0.
REQ-027 Assertion of Rst mid-operation SHALL discard all held pairs.
REQ-028 After deassertion, the first accept SHALL be possible at the first Clk edge.

Configuration
REQ-029 With MOD_OPERAND_STAGE_DZCNT_EN defined, the stage SHALL add output dz_count, 8 bits wide, as a saturating count (max 255) of accepted pairs with dz=1, reset to 0.
REQ-030 Without MOD_OPERAND_STAGE_DZCNT_EN, the dz_count port and its counter SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-031 Single pair: DATAWIDTH=8, a=0x17, b=0x05, out_ready=1 -> out_valid=1 one cycle later with out_a=0x17, out_b=0x05, out_dz=0; EMPTY the cycle after.
REQ-032 Divide-by-zero: a=0x2A, b=0x00 -> out_a=0x2A, out_b=0x01, out_dz=1; dz_count increments 0->1 when the macro is defined.
REQ-033 Backpressure: out_ready=0, three back-to-back valid pairs (1,1), (2,2), (3,3) -> the first two are accepted and in_ready=0 after the second; then out_ready=1 -> outputs in order (1,1), (2,2), then (3,3) accepted and delivered.
REQ-034 Streaming: 16 consecutive pairs with out_ready=1 throughout -> 16 outputs on 16 consecutive cycles, in order.
REQ-035 Reset mid-operation: state TWO, Rst asserted asynchronously between edges -> out_valid=0 and in_ready=1 immediately; no stale pair emerges after release.
REQ-036 Saturation: with the macro defined, 300 zero-divisor pairs -> dz_count=255.
